ps2_scancode_rx: RTL

//   PS/2 device-to-host receiver feeding the keyboard handler with raw scan codes.
//   - Samples ps2_clk/ps2_data in the system clock domain and deframes 11-bit frames.
//   - Checks each frame, then queues the data byte in a small FIFO.
//   - Exposes the ready / nextdata_n / overflow handshake the keyboard handler consumes.

---
 rtl/ps2_pkg.sv | 23 ++
 rtl/ps2_scancode_rx_fifo.sv | 65 ++++++
 rtl/ps2_scancode_rx.sv | 134 +++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : ps2_pkg                                                     |
// | Brief  : PS/2 frame constants, scan codes and parity helper          |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package ps2_pkg;
    localparam int         PS2_FRAME_BITS = 11;
    localparam logic       START_BIT      = 1'b0;
    localparam logic       STOP_BIT       = 1'b1;

    localparam logic [7:0] BREAK  = 8'hF0;
    localparam logic [7:0] EXT    = 8'hE0;
    localparam logic [7:0] LSHIFT = 8'h12;
    localparam logic [7:0] CTRL   = 8'h14;
    localparam logic [7:0] CAPS   = 8'h58;

    // {parity, data} must carry an odd number of ones
    function automatic logic odd_parity_ok(input logic [8:0] i_bits);
        return ^i_bits;
    endfunction
endpackage
`default_nettype wire

// File: rtl/ps2_scancode_rx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : sync_fifo                                                   |
// | Brief  : Single-clock FIFO with registered head-of-queue output      |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_empty,
    output logic             o_full,
    output logic [AW:0]      o_count
);
    localparam int c_DEPTH = 1 << AW;

    logic [WIDTH-1:0] r_mem [c_DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_cnt;
    logic [WIDTH-1:0] r_dout;
    logic             w_do_pop;
    logic             w_do_push;
    logic [AW-1:0]    w_rd_next;
    logic [AW:0]      w_cnt_next;

    assign o_empty    = (r_cnt == '0);
    assign o_full     = (r_cnt == (AW+1)'(c_DEPTH));
    assign o_count    = r_cnt;
    assign o_dout     = r_dout;
    assign w_do_pop   = i_pop & ~o_empty;
    // a push into a full FIFO is only accepted when a pop frees a slot
    assign w_do_push  = i_push & (~o_full | w_do_pop);
    assign w_rd_next  = r_rd + AW'(w_do_pop);
    assign w_cnt_next = r_cnt + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push)
            r_mem[r_wr] <= i_din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr   <= '0;
            r_rd   <= '0;
            r_cnt  <= '0;
            r_dout <= '0;
        end else begin
            if (w_do_push)
                r_wr <= r_wr + 1'b1;
            r_rd  <= w_rd_next;
            r_cnt <= w_cnt_next;
            // bypass when the new head is the slot being written this cycle
            if (w_cnt_next != '0)
                r_dout <= (w_do_push && (r_wr == w_rd_next)) ? i_din : r_mem[w_rd_next];
        end
    end
endmodule
`default_nettype wire

// File: rtl/ps2_scancode_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : ps2_scancode_rx                                             |
// | Brief  : PS/2 device-to-host deframer with scan-code FIFO            |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module ps2_scancode_rx
    import ps2_pkg::*;
#(
    parameter int FIFO_AW     = 3,
    parameter int SYNC_STAGES = 3,
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow,
    output logic       frame_err
);
    localparam int         c_TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [3:0] c_LAST_BIT = 4'(PS2_FRAME_BITS - 1);

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_dat_sync;
    logic                   r_clk_prev;
    logic                   r_nd_q;
    logic [3:0]             r_bit_cnt;
    logic [8:0]             r_shift;
    logic                   r_stop;
    logic                   r_done;
    logic [c_TO_W-1:0]      r_to_cnt;
    logic                   r_frame_err;
    logic                   r_overflow;

    logic                   w_fall;
    logic                   w_bit;
    logic                   w_timeout;
    logic                   w_good;
    logic                   w_pop;
    logic                   w_empty;
    logic                   w_full;
    logic [FIFO_AW:0]       w_count;

    assign w_fall    = r_clk_prev & ~r_clk_sync[SYNC_STAGES-1];
    assign w_bit     = r_dat_sync[SYNC_STAGES-1];
    assign w_timeout = (r_bit_cnt != '0) && !w_fall && (r_to_cnt == c_TO_W'(TIMEOUT_CYC - 1));
    assign w_good    = r_done && (r_stop == STOP_BIT) && odd_parity_ok(r_shift);
    assign w_pop     = r_nd_q & ~nextdata_n & ~w_empty;

    assign ready     = (w_count != '0);
    assign overflow  = r_overflow;
    assign frame_err = r_frame_err;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_clk_sync <= '1;
            r_dat_sync <= '1;
            r_clk_prev <= 1'b1;
            r_nd_q     <= 1'b1;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
            r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_data};
            r_clk_prev <= r_clk_sync[SYNC_STAGES-1];
            r_nd_q     <= nextdata_n;
        end
    end

    // bits 1..9 shift in from the top so data lands LSB-first in [7:0], parity in [8]
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_stop    <= 1'b0;
            r_done    <= 1'b0;
            r_to_cnt  <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_fall) begin
                r_to_cnt <= '0;
                if (r_bit_cnt == '0) begin
                    if (w_bit == START_BIT)
                        r_bit_cnt <= 4'd1;
                end else if (r_bit_cnt == c_LAST_BIT) begin
                    r_stop    <= w_bit;
                    r_done    <= 1'b1;
                    r_bit_cnt <= '0;
                end else begin
                    r_shift   <= {w_bit, r_shift[8:1]};
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end
            end else if (r_bit_cnt != '0) begin
                if (w_timeout) begin
                    r_bit_cnt <= '0;
                    r_to_cnt  <= '0;
                end else begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_frame_err <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_frame_err <= (r_done && !w_good) || w_timeout;
            if (w_pop)
                r_overflow <= 1'b0;
            else if (w_good && w_full)
                r_overflow <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (clrn),
        .i_push  (w_good),
        .i_pop   (w_pop),
        .i_din   (r_shift[7:0]),
        .o_dout  (data),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (w_count)
    );
endmodule
`default_nettype wire
